data_expander: RTL and testbench
================================

DATA_EXPANDER -- requirements
Module: data_expander

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per channel lane.
REQ-002 SHALL have parameter CH_COUNT, default 16, lanes per wide word (power of two).
REQ-003 SHALL have parameter TAG_WIDTH, default 1, sideband tag width.
REQ-004 SHALL have parameter _CFG_WIDTH, default $clog2(CH_COUNT), cfg_expand width.
REQ-005 SHALL have port clk  input  1  single clock for the whole block.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port cfg_expand  input  _CFG_WIDTH  mode k; output group size G = CH_COUNT>>k lanes, 2^k beats per word.
REQ-008 SHALL have ports s_in_data (CH_COUNT*DATA_WIDTH), s_in_keep (CH_COUNT), s_in_tag (TAG_WIDTH), s_in_valid, s_in_last as inputs and s_in_ready as output, all for the wide-word slave stream.
REQ-009 SHALL have ports m_out_data (CH_COUNT*DATA_WIDTH), m_out_tag (TAG_WIDTH), m_out_valid, m_out_last as outputs and m_out_ready as input, all for the narrow-beat master stream.

Function
REQ-010 SHALL transfer on valid&&ready at rising clk on both ports; m_out_* SHALL be registered and held stable while m_out_valid && !m_out_ready.
REQ-011 SHALL latch s_in_data, keep, tag, last and cfg_expand on input acceptance; later cfg_expand changes affect only the next word.
REQ-012 SHALL clamp cfg_expand values above $clog2(CH_COUNT) to $clog2(CH_COUNT).
REQ-013 SHALL emit beat s (s = 0..2^k-1) with m_out_data lanes [0..G-1] = latched lanes [s*G..s*G+G-1], lanes >= G driven zero.
REQ-014 SHALL present beat 0 on m_out the cycle after input acceptance (latency 1); one beat per cycle while m_out_ready is high.
REQ-015 SHALL drive m_out_tag with the latched tag on every beat of the word.
REQ-016 SHALL assert m_out_last only on the final beat of a word whose latched s_in_last was 1.
REQ-017 SHALL use states IDLE (no word held) and EMIT (beats pending); IDLE->EMIT on acceptance; EMIT->IDLE when final beat accepted and no new word is accepted in the same cycle.
REQ-018 SHALL assert s_in_ready in IDLE, or in EMIT when the final beat is being accepted this cycle (back-to-back words, no bubble); mode 0 SHALL sustain one word per cycle.
REQ-019 SHALL wrap the beat counter to 0 on every new word; counter width $clog2(CH_COUNT)+1 to avoid overflow in max mode.

Reset
REQ-020 SHALL on rst: m_out_valid=0, m_out_last=0, beat counter=0, state IDLE, s_in_ready=1 the cycle after rst deasserts; data/tag registers need no reset.
REQ-021 SHALL abandon any word in progress on rst mid-word; no partial beats appear after reset.

Configuration
REQ-022 SHALL honour macro DATA_EXPANDER_KEEP_TRIM_EN: defined -> final beat is the highest beat whose group has any s_in_keep bit set (word with keep=0 emits beat 0 only); undefined -> s_in_keep ignored, always 2^k beats.

Structure
REQ-023 SHALL place mode encoding constants, group-size and beat-count functions in shared package data_compact_pkg, common with the compacting direction.
REQ-024 SHALL implement lane selection as sub-module data_expander_lane_sel (combinational group mux); control FSM stays in data_expander.

Verification
REQ-025 SHALL test mode 0, words 0x0..., keep all ones, m_out_ready=1 -> one beat per cycle, data identical to input, latency 1.
REQ-026 SHALL test mode 2 (G=4), lanes i=i, last=1 -> 4 beats with lanes 0..3 = {0..3},{4..7},{8..11},{12..15}, m_out_last only on beat 3, lanes 4..15 zero.
REQ-027 SHALL test mode 4, m_out_ready toggling 1010 -> 16 beats, data stable during stall, s_in_ready high only with final-beat acceptance.
REQ-028 SHALL test with DATA_EXPANDER_KEEP_TRIM_EN, mode 2, keep=0x00FF -> exactly 2 beats; without macro -> 4 beats.
REQ-029 SHALL test rst asserted during beat 1 of mode 3 -> m_out_valid=0 next cycle, next word starts at beat 0.
REQ-030 SHALL test cfg_expand changed 2->1 during EMIT -> current word keeps 4 beats, next word emits 2.

Source files
------------

// File: rtl/data_compact_pkg.sv
// Shared helpers for the data compacting/expanding pair.
// Mode k splits a CH_COUNT-lane word into 2^k beats of CH_COUNT>>k lanes.
package data_compact_pkg;

  // Mode 0: the whole word travels in a single beat.
  localparam int MODE_FULL = 0;

  // Limit a requested mode to the deepest split the lane count allows.
  function automatic int clamp_mode(input int k, input int k_max);
    return (k > k_max) ? k_max : k;
  endfunction

  // Lanes carried per beat in mode k.
  function automatic int group_size(input int k, input int ch_count);
    return ch_count >> k;
  endfunction

  // Beats needed to carry a full word in mode k.
  function automatic int beat_count(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/data_expander_if.sv
// Wide-word slave stream and narrow-beat master stream of the expander.
// Handshake: a beat moves on a rising clk when valid && ready are both high;
// the sender holds every payload signal stable while valid && !ready.
interface data_expander_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_COUNT   = 16,
  parameter int TAG_WIDTH  = 1
);
  logic [CH_COUNT*DATA_WIDTH-1:0] s_in_data;
  logic [CH_COUNT-1:0]            s_in_keep;
  logic [TAG_WIDTH-1:0]           s_in_tag;
  logic                           s_in_valid;
  logic                           s_in_last;
  logic                           s_in_ready;

  logic [CH_COUNT*DATA_WIDTH-1:0] m_out_data;
  logic [TAG_WIDTH-1:0]           m_out_tag;
  logic                           m_out_valid;
  logic                           m_out_last;
  logic                           m_out_ready;

  // Word producer / beat consumer side.
  modport master (
    output s_in_data, s_in_keep, s_in_tag, s_in_valid, s_in_last,
    input  s_in_ready,
    input  m_out_data, m_out_tag, m_out_valid, m_out_last,
    output m_out_ready
  );

  // Expander side.
  modport slave (
    input  s_in_data, s_in_keep, s_in_tag, s_in_valid, s_in_last,
    output s_in_ready,
    output m_out_data, m_out_tag, m_out_valid, m_out_last,
    input  m_out_ready
  );
endinterface

// File: rtl/data_expander_lane_sel.sv
// Combinational group mux: picks lane group beat_i of a word split in mode
// mode_i and places it in the low lanes, upper lanes forced to zero.
module data_expander_lane_sel
  import data_compact_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CH_COUNT   = 16,
  parameter int SEL_WIDTH  = 5
) (
  input  logic [CH_COUNT*DATA_WIDTH-1:0] data_i,
  input  logic [SEL_WIDTH-1:0]           beat_i,
  input  logic [SEL_WIDTH-1:0]           mode_i,
  output logic [CH_COUNT*DATA_WIDTH-1:0] data_o
);
  localparam int W = CH_COUNT * DATA_WIDTH;

  int           grp;
  logic [W-1:0] mask;

  // Shift the selected group down to lane 0 and clear everything above it.
  always_comb begin
    grp    = group_size(int'(mode_i), CH_COUNT);
    mask   = '1;
    mask   = mask >> (W - grp * DATA_WIDTH);
    data_o = (data_i >> (int'(beat_i) * grp * DATA_WIDTH)) & mask;
  end
endmodule

// File: rtl/data_expander.sv
// data_expander: splits each accepted wide word into 2^k narrow beats.
// Optional macro DATA_EXPANDER_KEEP_TRIM_EN: stop after the highest beat whose
// lane group has any keep bit set (keep == 0 still emits beat 0).
module data_expander
  import data_compact_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CH_COUNT   = 16,
  parameter int TAG_WIDTH  = 1,
  parameter int _CFG_WIDTH = $clog2(CH_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [_CFG_WIDTH-1:0] cfg_expand,
  data_expander_if.slave        bus,
  output logic [1:0]            dbg_state_o
);
  localparam int W     = CH_COUNT * DATA_WIDTH;
  localparam int K_MAX = $clog2(CH_COUNT);
  localparam int CW    = K_MAX + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        beat_q, beat_d;
  logic [CW-1:0]        last_beat_q, last_beat_d;
  logic [CW-1:0]        mode_q, mode_d;
  logic [W-1:0]         data_q, data_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 wlast_q, wlast_d;
  logic                 mv_q, mv_d;
  logic                 ml_q, ml_d;
  logic [W-1:0]         md_q, md_d;
  logic [TAG_WIDTH-1:0] mt_q, mt_d;

  logic          out_fire, final_fire, in_fire, s_ready;
  logic [CW-1:0] in_mode, in_last_beat, beat_nxt;
  logic [W-1:0]  sel_src, sel_out;
  logic [CW-1:0] sel_beat, sel_mode;

  assign in_mode    = CW'(clamp_mode(int'(cfg_expand), K_MAX));
  assign beat_nxt   = beat_q + CW'(1);
  assign out_fire   = mv_q && bus.m_out_ready;
  assign final_fire = out_fire && (beat_q == last_beat_q);
  // A new word may enter while the previous one's final beat leaves.
  assign s_ready    = (state_q == ST_IDLE) || final_fire;
  assign in_fire    = bus.s_in_valid && s_ready;

`ifdef DATA_EXPANDER_KEEP_TRIM_EN
  int                  trim_g;
  logic [CH_COUNT-1:0] trim_mask;

  // Final beat is the highest group holding any kept lane.
  always_comb begin
    trim_g       = group_size(int'(in_mode), CH_COUNT);
    trim_mask    = '1;
    trim_mask    = trim_mask >> (CH_COUNT - trim_g);
    in_last_beat = '0;
    for (int s = 0; s < CH_COUNT; s++) begin
      if ((s < beat_count(int'(in_mode))) &&
          (((bus.s_in_keep >> (s * trim_g)) & trim_mask) != '0)) begin
        in_last_beat = CW'(s);
      end
    end
  end
`else
  logic unused_keep;
  assign unused_keep  = ^bus.s_in_keep;
  assign in_last_beat = CW'(beat_count(int'(in_mode)) - 1);
`endif

  // Beat 0 comes straight from the input word; later beats from the held copy.
  always_comb begin
    if (in_fire) begin
      sel_src  = bus.s_in_data;
      sel_beat = '0;
      sel_mode = in_mode;
    end else begin
      sel_src  = data_q;
      sel_beat = beat_nxt;
      sel_mode = mode_q;
    end
  end

  data_expander_lane_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .CH_COUNT   (CH_COUNT),
    .SEL_WIDTH  (CW)
  ) u_lane_sel (
    .data_i (sel_src),
    .beat_i (sel_beat),
    .mode_i (sel_mode),
    .data_o (sel_out)
  );

  // Next state: load a new word, retire the final beat, or advance one beat.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mv_d        = mv_q;
    ml_d        = ml_q;
    data_d      = data_q;
    tag_d       = tag_q;
    wlast_d     = wlast_q;
    mode_d      = mode_q;
    last_beat_d = last_beat_q;
    md_d        = md_q;
    mt_d        = mt_q;
    if (in_fire) begin
      state_d     = ST_EMIT;
      beat_d      = '0;
      mv_d        = 1'b1;
      ml_d        = bus.s_in_last && (in_last_beat == '0);
      data_d      = bus.s_in_data;
      tag_d       = bus.s_in_tag;
      wlast_d     = bus.s_in_last;
      mode_d      = in_mode;
      last_beat_d = in_last_beat;
      md_d        = sel_out;
      mt_d        = bus.s_in_tag;
    end else if (final_fire) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      mv_d    = 1'b0;
      ml_d    = 1'b0;
    end else if (out_fire) begin
      beat_d = beat_nxt;
      md_d   = sel_out;
      ml_d   = wlast_q && (beat_nxt == last_beat_q);
    end
  end

  // Control registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
    end
  end

  // Payload registers; only meaningful while a word is held.
  always_ff @(posedge clk) begin
    data_q      <= data_d;
    tag_q       <= tag_d;
    wlast_q     <= wlast_d;
    mode_q      <= mode_d;
    last_beat_q <= last_beat_d;
    md_q        <= md_d;
    mt_q        <= mt_d;
  end

  assign bus.s_in_ready  = s_ready;
  assign bus.m_out_valid = mv_q;
  assign bus.m_out_last  = ml_q;
  assign bus.m_out_data  = md_q;
  assign bus.m_out_tag   = mt_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_data_expander.sv
// Self-checking bench for data_expander: directed scenarios plus a random
// phase, all checked by a scoreboard fed from a lane-array reference model.
module tb_data_expander;
  localparam int DW   = 16;
  localparam int CH   = 16;
  localparam int TW   = 1;
  localparam int CFGW = 4;
  localparam int KMAX = 4;
  localparam int W    = CH * DW;
  localparam int BW   = W + TW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [CFGW-1:0] cfg_expand;
  logic [1:0]      dbg_state;

  data_expander_if #(.DATA_WIDTH(DW), .CH_COUNT(CH), .TAG_WIDTH(TW)) bus ();

  data_expander #(
    .DATA_WIDTH (DW),
    .CH_COUNT   (CH),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_expand  (cfg_expand),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: word as lane array, mode clamped, beats listed directly.
  function automatic void model_push(input logic [W-1:0] d, input logic [CH-1:0] kp,
                                     input logic [TW-1:0] tg, input logic ls, input int cfg);
    int k, g, nb;
    logic [DW-1:0] lanes[CH];
    logic [W-1:0]  beat;
    k  = (cfg > KMAX) ? KMAX : cfg;
    g  = CH >> k;
    nb = 1 << k;
    for (int i = 0; i < CH; i++) lanes[i] = d[i*DW +: DW];
`ifdef DATA_EXPANDER_KEEP_TRIM_EN
    nb = 1;
    for (int s = 0; s < (1 << k); s++) begin
      for (int j = 0; j < g; j++) begin
        if (kp[s*g + j]) nb = s + 1;
      end
    end
`else
    if (kp != kp) nb = 0;
`endif
    for (int s = 0; s < nb; s++) begin
      beat = '0;
      for (int j = 0; j < g; j++) beat[j*DW +: DW] = lanes[s*g + j];
      exp_q.push_back({beat, tg, ls && (s == nb - 1)});
    end
  endfunction

  // ---------------- output-ready generator ----------------
  initial begin
    bus.m_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.m_out_ready = 1'b1;
        1:       bus.m_out_ready = ~bus.m_out_ready;
        default: bus.m_out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [BW-1:0] got, exp, held;
    logic held_v, acc_pend, exp_rdy;
    held_v   = 1'b0;
    acc_pend = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v   = 1'b0;
        acc_pend = 1'b0;
      end else begin
        if (acc_pend) check("latency1_valid", BW'(bus.m_out_valid), BW'(1));
        acc_pend = bus.s_in_valid && bus.s_in_ready;
        exp_rdy  = (exp_q.size() == 0) ||
                   (exp_q.size() == 1 && bus.m_out_valid && bus.m_out_ready);
        check("s_in_ready", BW'(bus.s_in_ready), BW'(exp_rdy));
        got = {bus.m_out_data, bus.m_out_tag, bus.m_out_last};
        if (held_v) check("stall_stable", {bus.m_out_valid, got}, {1'b1, held});
        held_v = bus.m_out_valid && !bus.m_out_ready;
        held   = got;
        if (bus.m_out_valid && bus.m_out_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", got, '0);
          end else begin
            exp = exp_q.pop_front();
            check("beat", got, exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic [CH-1:0] kp,
                           input logic [TW-1:0] tg, input logic ls, input logic [CFGW-1:0] cfg);
    int n;
    n = 0;
    bus.s_in_data  = d;
    bus.s_in_keep  = kp;
    bus.s_in_tag   = tg;
    bus.s_in_last  = ls;
    cfg_expand     = cfg;
    bus.s_in_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_in_ready) begin
      check("accept_timeout", BW'(bus.s_in_ready), BW'(1));
      @(posedge clk);
      #1 bus.s_in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_push(d, kp, tg, ls, int'(cfg));
      #1 bus.s_in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", BW'(exp_q.size()), BW'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [W-1:0] index_word();
    logic [W-1:0] d;
    for (int i = 0; i < CH; i++) d[i*DW +: DW] = DW'(i);
    return d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int b0, t0, nb_exp;
    logic [W-1:0] w;
    logic [CH-1:0] kp;
    rst            = 1'b1;
    cfg_expand     = '0;
    bus.s_in_data  = '0;
    bus.s_in_keep  = '0;
    bus.s_in_tag   = '0;
    bus.s_in_last  = 1'b0;
    bus.s_in_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_out_valid", BW'(bus.m_out_valid), BW'(0));
    check("rst_m_out_last", BW'(bus.m_out_last), BW'(0));
    check("rst_s_in_ready", BW'(bus.s_in_ready), BW'(1));
    check("rst_state_idle", BW'(dbg_state), BW'(0));
    idle(1);

    // Mode 0, full keep, always ready: one word per cycle, data unchanged.
    ready_mode = 0;
    idle(2);
    b0 = beats_seen;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? '0 : rand_word();
      send_word(w, '1, TW'(i), (i % 3) == 0, 4'd0);
    end
    check("mode0_rate_cycles", BW'(cyc - t0), BW'(8));
    drain();
    check("mode0_beats", BW'(beats_seen - b0), BW'(8));

    // Mode 2, lanes i=i, last set: four groups of four.
    b0 = beats_seen;
    send_word(index_word(), '1, 1'b1, 1'b1, 4'd2);
    drain();
    check("mode2_beats", BW'(beats_seen - b0), BW'(4));

    // Mode 4 with ready toggling, two words back to back.
    ready_mode = 1;
    idle(2);
    b0 = beats_seen;
    send_word(rand_word(), '1, 1'b0, 1'b1, 4'd4);
    send_word(rand_word(), '1, 1'b1, 1'b0, 4'd4);
    drain();
    check("mode4_beats", BW'(beats_seen - b0), BW'(32));

    // Keep trimming in mode 2.
    ready_mode = 0;
    idle(2);
`ifdef DATA_EXPANDER_KEEP_TRIM_EN
    nb_exp = 2;
`else
    nb_exp = 4;
`endif
    b0 = beats_seen;
    send_word(rand_word(), 16'h00FF, 1'b1, 1'b1, 4'd2);
    drain();
    check("keep_00ff_beats", BW'(beats_seen - b0), BW'(nb_exp));
`ifdef DATA_EXPANDER_KEEP_TRIM_EN
    nb_exp = 1;
`else
    nb_exp = 4;
`endif
    b0 = beats_seen;
    send_word(rand_word(), 16'h0000, 1'b0, 1'b1, 4'd2);
    drain();
    check("keep_zero_beats", BW'(beats_seen - b0), BW'(nb_exp));

    // Reset during beat 1 of a mode 3 word.
    send_word(rand_word(), '1, 1'b1, 1'b1, 4'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", BW'(bus.m_out_valid), BW'(0));
    check("rst_mid_ready", BW'(bus.s_in_ready), BW'(1));
    idle(1);
    b0 = beats_seen;
    send_word(index_word(), '1, 1'b0, 1'b1, 4'd3);
    drain();
    check("post_rst_beats", BW'(beats_seen - b0), BW'(8));

    // cfg change during EMIT only affects the next word.
    b0 = beats_seen;
    send_word(rand_word(), '1, 1'b1, 1'b1, 4'd2);
    cfg_expand = 4'd1;
    @(negedge clk);
    check("emit_state", BW'(dbg_state), BW'(1));
    drain();
    check("cfg_old_beats", BW'(beats_seen - b0), BW'(4));
    b0 = beats_seen;
    send_word(rand_word(), '1, 1'b0, 1'b1, 4'd1);
    drain();
    check("cfg_new_beats", BW'(beats_seen - b0), BW'(2));

    // Random phase: modes 0..15 (clamped), random keep, random output stalls.
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       kp = '1;
        1:       kp = '0;
        default: kp = CH'($urandom());
      endcase
      send_word(rand_word(), kp, TW'($urandom()), 1'($urandom()),
                CFGW'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) begin
        cfg_expand = CFGW'($urandom());
        idle(1);
      end
    end
    drain();
    check("final_queue_empty", BW'(exp_q.size()), BW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
